bcd_seq_adder: RTL and testbench
================================

BCD_SEQ_ADDER -- requirements
Module: bcd_seq_adder

Interface
REQ-001 Parameter: DIGITS, default 4, number of packed BCD digits per operand (legal range 1..16).
REQ-002 Port: clk  input  1  clock; all state changes on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  request to begin an add; sampled on rising clk.
REQ-005 Port: x  input  4*DIGITS  packed BCD operand X; digit 0 in bits [3:0].
REQ-006 Port: y  input  4*DIGITS  packed BCD operand Y; same packing as x.
REQ-007 Port: c_in  input  1  decimal carry-in to digit 0.
REQ-008 Port: busy  output  1  high while an operation is in progress.
REQ-009 Port: done  output  1  one-cycle pulse marking result valid.
REQ-010 Port: result  output  4*DIGITS  packed BCD sum, same packing as x.
REQ-011 Port: c_out  output  1  decimal carry out of the most significant digit.
REQ-012 Port: out_of_range  output  1  high when any x or y digit of the operation exceeded 9.

Function
REQ-013 The FSM SHALL have three states: IDLE, ADD and DONE.
REQ-014 In IDLE or DONE, start=1 at a rising edge SHALL capture x, y and c_in into internal registers, clear the digit counter and enter ADD.
REQ-015 start SHALL be ignored while in ADD; captured operands SHALL NOT change during an operation.
REQ-016 ADD SHALL process one digit per cycle, LSD first: s = xd + yd + carry; s > 9 -> digit = s - 10, carry = 1; otherwise digit = s, carry = 0.
REQ-017 All intermediate sums SHALL be at least 5 bits wide, so the worst case 15+15+1 = 31 does not overflow.
REQ-018 The carry into digit 0 SHALL be captured c_in; the carry out of digit i SHALL feed digit i+1 on the next cycle.
REQ-019 An internal sticky flag SHALL set when any captured x or y digit is 10..15 and SHALL clear on each accepted start.
REQ-020 After the edge that processes digit DIGITS-1, the FSM SHALL enter DONE and update result, c_out and out_of_range on that same edge.
REQ-021 Latency: with the start-accept edge as edge 0, done SHALL be high for exactly the one cycle following edge DIGITS.
REQ-022 busy SHALL be 1 exactly in ADD, for DIGITS cycles, and 0 in IDLE and DONE.
REQ-023 If the sticky flag is set at completion, the block SHALL drive result = 0, c_out = 0 and out_of_range = 1.
REQ-024 Otherwise the block SHALL drive the BCD sum, the final carry and out_of_range = 0.
REQ-025 result, c_out and out_of_range SHALL hold their values until the completion edge of the next operation.
REQ-026 From DONE, start=0 SHALL return the FSM to IDLE; start=1 SHALL begin a new operation back-to-back, with done deasserting.
REQ-027 When c_in = 1 and x + y = 10^DIGITS - 1, all result digits SHALL be 0 and c_out = 1.

Reset
REQ-028 Asserting reset SHALL immediately, with no clock edge, force the following:
- state = IDLE
- busy = 0, done = 0
- result = 0, c_out = 0, out_of_range = 0
- digit counter = 0, internal carry = 0, sticky flag = 0
REQ-029 Reset asserted mid-operation SHALL abort the operation with no done pulse; start is ignored while reset is high.
REQ-030 The first start after reset deassertion SHALL behave exactly per REQ-014.

Verification (DIGITS = 4)
REQ-031 x=1234, y=5678, c_in=0, start pulse -> busy high 4 cycles, done pulse, result=6912, c_out=0, out_of_range=0.
REQ-032 x=9999, y=0000, c_in=1 -> result=0000, c_out=1, out_of_range=0.
REQ-033 x=12A4 (digit 10 in position 1), y=0001, c_in=0 -> result=0000, c_out=0, out_of_range=1; the next valid operation clears out_of_range.
REQ-034 Start 0005+0005, then start with x=1111, y=1111 during busy -> second start ignored, result=0010, single done pulse.
REQ-035 Reset asserted 2 cycles after start -> busy=0, done=0, result=0 immediately; no done pulse follows.
REQ-036 start held high through DONE with 0045+0055, then 0999+0001 -> consecutive results 0100 then 1000, each with its own done pulse.
REQ-037 Exhaustive single-digit sweep: all x, y in 0..15 on digit 0 with c_in in {0, 1} -> matches the reference model per REQ-016 and REQ-023.

Source files
------------

// File: rtl/bcd_seq_adder.sv
// Sequential packed-BCD adder: one digit per clock, LSD first.
// Operands with non-decimal digits produce a zero result and out_of_range.
module bcd_seq_adder #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   x,
  input  logic [4*DIGITS-1:0]   y,
  input  logic                  c_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   result,
  output logic                  c_out,
  output logic                  out_of_range
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [W-1:0]  xr;
  logic [W-1:0]  yr;
  logic [W-1:0]  acc;
  logic [W-1:0]  acc_n;
  logic [CW-1:0] cnt;
  logic          carry;
  logic          sticky;
  logic [4:0]    sum;
  logic          hi;
  logic [3:0]    dig;
  logic          accept;
  logic          last;

  function automatic logic any_bad(input logic [W-1:0] v);
    any_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) any_bad = 1'b1;
    end
  endfunction

  assign accept = start && (state != ADD);
  assign last   = (state == ADD) && (cnt == LAST);
  assign busy   = (state == ADD);
  assign done   = (state == DONE);

  // Current digit sum; operands shift right so digit 0 is always in [3:0]
  always_comb begin
    sum   = {1'b0, xr[3:0]} + {1'b0, yr[3:0]} + {4'b0, carry};
    hi    = (sum > 5'd9);
    dig   = hi ? 4'(sum - 5'd10) : sum[3:0];
    acc_n = (acc >> 4) | (W'(dig) << (W - 4));
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = ADD;
      ADD:     if (last)  state_n = DONE;
      DONE:    state_n = start ? ADD : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Operand capture, digit-serial datapath and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xr           <= '0;
      yr           <= '0;
      acc          <= '0;
      cnt          <= '0;
      carry        <= 1'b0;
      sticky       <= 1'b0;
      result       <= '0;
      c_out        <= 1'b0;
      out_of_range <= 1'b0;
    end else if (accept) begin
      xr     <= x;
      yr     <= y;
      acc    <= '0;
      cnt    <= '0;
      carry  <= c_in;
      sticky <= any_bad(x) | any_bad(y);
    end else if (state == ADD) begin
      xr    <= xr >> 4;
      yr    <= yr >> 4;
      acc   <= acc_n;
      cnt   <= cnt + CW'(1);
      carry <= hi;
      if (last) begin
        result       <= sticky ? '0 : acc_n;
        c_out        <= sticky ? 1'b0 : hi;
        out_of_range <= sticky;
      end
    end
  end

endmodule

// File: tb/tb_bcd_seq_adder.sv
// Scoreboard bench for bcd_seq_adder (DIGITS = 4).
// Directed vectors push expectations; a monitor checks each done pulse.
module tb_bcd_seq_adder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] x;
  logic [15:0] y;
  logic        c_in;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        c_out;
  logic        out_of_range;

  typedef struct packed {
    logic [15:0] r;
    logic        c;
    logic        o;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_err  = 0;
  int   n_push = 0;
  int   n_done = 0;
  logic pd     = 1'b0;

  bcd_seq_adder #(.DIGITS(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .x            (x),
    .y            (y),
    .c_in         (c_in),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .c_out        (c_out),
    .out_of_range (out_of_range)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               nm, got, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      pd = 1'b0;
    end else begin
      if (done && pd) chk("done_width", 32'd2, 32'd1);
      if (done) begin
        n_done++;
        if (q.size() == 0) begin
          chk("spurious_done", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("result", 32'(result), 32'(e.r));
          chk("c_out", 32'(c_out), 32'(e.c));
          chk("oor", 32'(out_of_range), 32'(e.o));
        end
      end
      pd = done;
    end
  end

  task automatic expect_res(input logic [15:0] r,
                            input logic c, input logic o);
    exp_t e;
    e.r = r;
    e.c = c;
    e.o = o;
    q.push_back(e);
    n_push++;
  endtask

  task automatic wait_empty();
    int k = 0;
    while (q.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (q.size() != 0) begin
      chk("done_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
  endtask

  task automatic op(input logic [15:0] a, input logic [15:0] b,
                    input logic ci, input logic [15:0] er,
                    input logic ec, input logic eo);
    int n = 0;
    x     = a;
    y     = b;
    c_in  = ci;
    start = 1'b1;
    expect_res(er, ec, eo);
    @(negedge clk);
    start = 1'b0;
    while (busy && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("busy_cycles", 32'(n), 32'd4);
    wait_empty();
  endtask

  initial begin
    logic [15:0] er;
    logic        eo;
    int          s;
    reset = 1'b1;
    start = 1'b0;
    x     = '0;
    y     = '0;
    c_in  = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_cout", 32'(c_out), 32'd0);
    chk("rst_oor", 32'(out_of_range), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    op(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
    op(16'h9999, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    op(16'h12A4, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1);
    op(16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0);
    op(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    op(16'h4321, 16'h0FFF, 1'b0, 16'h0000, 1'b0, 1'b1);
    op(16'h0458, 16'h0567, 1'b1, 16'h1026, 1'b0, 1'b0);

    // Start during busy must be ignored
    x     = 16'h0005;
    y     = 16'h0005;
    c_in  = 1'b0;
    start = 1'b1;
    expect_res(16'h0010, 1'b0, 1'b0);
    @(negedge clk);
    x = 16'h1111;
    y = 16'h1111;
    @(negedge clk);
    start = 1'b0;
    wait_empty();
    repeat (6) @(negedge clk);

    // Reset mid-operation aborts immediately
    x     = 16'h1234;
    y     = 16'h5678;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_cout", 32'(c_out), 32'd0);
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("post_abort_busy", 32'(busy), 32'd0);

    // start held through DONE: back-to-back operations
    x     = 16'h0045;
    y     = 16'h0055;
    c_in  = 1'b0;
    start = 1'b1;
    expect_res(16'h0100, 1'b0, 1'b0);
    @(negedge clk);
    x = 16'h0999;
    y = 16'h0001;
    expect_res(16'h1000, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    start = 1'b0;
    wait_empty();
    @(negedge clk);

    // Single-digit sweep against a decimal reference
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          if (a > 9 || b > 9) begin
            er = 16'h0000;
            eo = 1'b1;
          end else begin
            s  = a + b + c;
            er = (s > 9) ? 16'(16 + s - 10) : 16'(s);
            eo = 1'b0;
          end
          op(16'(a), 16'(b), c[0], er, 1'b0, eo);
        end
      end
    end

    repeat (4) @(negedge clk);
    chk("done_count", 32'(n_done), 32'(n_push));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
